// File: rtl/position_pd_sequencer_if.sv
// Signal bundle between the sensor/gain registers and the PD sequencer.
// Master drives the loop inputs; slave (the sequencer) drives the PWM result.
interface position_pd_sequencer_if;
    logic               enable;
    logic [15:0]        Sensor;
    logic [15:0]        positon_target;
    logic [15:0]        posi_kp;
    logic [15:0]        posi_kd;
    logic signed [15:0] Position_pwm;
    logic               pwm_valid;
    logic               busy;
    logic               sat;

    modport master (
        output enable, Sensor, positon_target, posi_kp, posi_kd,
        input  Position_pwm, pwm_valid, busy, sat
    );

    modport slave (
        input  enable, Sensor, positon_target, posi_kp, posi_kd,
        output Position_pwm, pwm_valid, busy, sat
    );
endinterface

// File: rtl/position_pd_sequencer.sv
// Periodic PD sequencer: one shared 17x17 signed multiplier computes the P then the D term.
// Optional error deadband is enabled by defining PD_DEADBAND_EN.
module position_pd_sequencer #(
    parameter int unsigned DIV      = 1000,
    parameter int          OUT_MAX  = 32767,
    parameter int          OUT_MIN  = -32768,
    parameter int unsigned DEADBAND = 4
) (
    input logic                    clk,
    input logic                    rst,
    position_pd_sequencer_if.slave bus
);

    if (DIV < 8 || DIV > 65535 || OUT_MIN >= OUT_MAX || DEADBAND > 65535) begin : g_bad_cfg
        $error("position_pd_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {StIdle, StSample, StMulP, StMulD, StSat, StOut} state_e;

    localparam logic [15:0]        DivLast  = 16'(DIV - 1);
    localparam logic signed [35:0] OutMaxW  = 36'(OUT_MAX);
    localparam logic signed [35:0] OutMinW  = 36'(OUT_MIN);
    localparam logic signed [15:0] OutMax16 = 16'(OUT_MAX);
    localparam logic signed [15:0] OutMin16 = 16'(OUT_MIN);

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               first_q, first_d;
    logic signed [16:0] err_q, err_d;
    logic signed [16:0] err_prev_q, err_prev_d;
    logic signed [17:0] derr_q, derr_d;
    logic [15:0]        kp_q, kp_d, kd_q, kd_d;
    logic signed [35:0] acc_q, acc_d;
    logic signed [15:0] pwm_q, pwm_d;
    logic               valid_q, valid_d;
    logic               sat_q, sat_d;

    logic               tick;
    logic signed [16:0] err_raw, err_s, derr_clip, mul_a, mul_b;
    logic signed [17:0] derr_raw;
    logic signed [33:0] prod;
    logic signed [35:0] prod_ext;

    assign tick = bus.enable && (cnt_q == DivLast);

    always_comb begin
        err_raw = $signed({1'b0, bus.positon_target}) - $signed({1'b0, bus.Sensor});
`ifdef PD_DEADBAND_EN
        if ((err_raw <= $signed(17'(DEADBAND))) && (err_raw >= -$signed(17'(DEADBAND)))) begin
            err_s = '0;
        end else begin
            err_s = err_raw;
        end
`else
        err_s = err_raw;
`endif
        derr_raw = $signed({err_s[16], err_s}) - $signed({err_prev_q[16], err_prev_q});
    end

    // Clamp the 18-bit derivative into the multiplier's 17-bit signed operand range.
    always_comb begin
        if (!derr_q[17] && derr_q[16]) begin
            derr_clip = 17'sh0FFFF;
        end else if (derr_q[17] && !derr_q[16]) begin
            derr_clip = $signed(17'h10000);
        end else begin
            derr_clip = derr_q[16:0];
        end
    end

    // The single shared multiplier: P operands in MUL_P, D operands in MUL_D.
    always_comb begin
        if (state_q == StMulD) begin
            mul_a = derr_clip;
            mul_b = $signed({1'b0, kd_q});
        end else begin
            mul_a = err_q;
            mul_b = $signed({1'b0, kp_q});
        end
        prod     = mul_a * mul_b;
        prod_ext = {{2{prod[33]}}, prod};
    end

    always_comb begin
        if (!bus.enable || cnt_q == DivLast) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        err_d      = err_q;
        err_prev_d = err_prev_q;
        derr_d     = derr_q;
        kp_d       = kp_q;
        kd_d       = kd_q;
        acc_d      = acc_q;
        pwm_d      = pwm_q;
        sat_d      = sat_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tick) state_d = StSample;
            end
            StSample: begin
                kp_d       = bus.posi_kp;
                kd_d       = bus.posi_kd;
                err_d      = err_s;
                err_prev_d = err_s;
                derr_d     = first_q ? '0 : derr_raw;
                first_d    = 1'b0;
                state_d    = StMulP;
            end
            StMulP: begin
                acc_d   = prod_ext;
                state_d = StMulD;
            end
            StMulD: begin
                acc_d   = acc_q + prod_ext;
                state_d = StSat;
            end
            StSat: begin
                if (acc_q > OutMaxW) begin
                    pwm_d = OutMax16;
                    sat_d = 1'b1;
                end else if (acc_q < OutMinW) begin
                    pwm_d = OutMin16;
                    sat_d = 1'b1;
                end else begin
                    pwm_d = acc_q[15:0];
                    sat_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disabling the loop forgets the error history so the next run has no derivative kick.
        if (!bus.enable) first_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            err_q      <= '0;
            err_prev_q <= '0;
            derr_q     <= '0;
            kp_q       <= '0;
            kd_q       <= '0;
            acc_q      <= '0;
            pwm_q      <= '0;
            sat_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            err_q      <= err_d;
            err_prev_q <= err_prev_d;
            derr_q     <= derr_d;
            kp_q       <= kp_d;
            kd_q       <= kd_d;
            acc_q      <= acc_d;
            pwm_q      <= pwm_d;
            sat_q      <= sat_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.Position_pwm = pwm_q;
    assign bus.pwm_valid    = valid_q;
    assign bus.sat          = sat_q;
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_position_pd_sequencer.sv
// Directed bench for position_pd_sequencer with DIV=10; expected values hand-computed.
module tb_position_pd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    position_pd_sequencer_if bus_if ();

    position_pd_sequencer #(
        .DIV      (10),
        .OUT_MAX  (32767),
        .OUT_MIN  (-32768),
        .DEADBAND (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Steps one edge at a time until pwm_valid; n=-1 if it never arrives.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.pwm_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic set_in(input logic [15:0] tgt, input logic [15:0] sen,
                          input logic [15:0] kp, input logic [15:0] kd);
        bus_if.positon_target = tgt;
        bus_if.Sensor         = sen;
        bus_if.posi_kp        = kp;
        bus_if.posi_kd        = kd;
    endtask

    task automatic test_reset();
        bus_if.enable = 1'b1;
        set_in(16'd2000, 16'd5000, 16'd1, 16'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.Position_pwm !== 16'sd0 || bus_if.pwm_valid !== 1'b0 ||
            bus_if.busy !== 1'b0 || bus_if.sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pwm=%0d valid=%b busy=%b sat=%b expected 0 0 0 0",
                     bus_if.Position_pwm, bus_if.pwm_valid, bus_if.busy, bus_if.sat);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_p();
        int n;
        wait_valid(n);
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL first_latency: got %0d edges expected 14", n);
        end
        checks++;
        if (bus_if.Position_pwm !== -16'sd3000 || bus_if.sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_p: pwm=%0d sat=%b expected -3000 0",
                     bus_if.Position_pwm, bus_if.sat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.pwm_valid !== 1'b0 || bus_if.Position_pwm !== -16'sd3000) begin
            errors++;
            $display("FAIL valid_one_cycle: valid=%b pwm=%0d expected 0 -3000",
                     bus_if.pwm_valid, bus_if.Position_pwm);
        end
    endtask

    task automatic test_derivative();
        int n;
        bus_if.Sensor = 16'd3000;
        wait_valid(n);
        checks++;
        if (n != 9 || bus_if.Position_pwm !== 16'sd1000) begin
            errors++;
            $display("FAIL deriv_1: edges=%0d pwm=%0d expected 9 1000", n, bus_if.Position_pwm);
        end
        bus_if.Sensor = 16'd2500;
        wait_valid(n);
        checks++;
        if (n != 10 || bus_if.Position_pwm !== 16'sd0) begin
            errors++;
            $display("FAIL deriv_2: edges=%0d pwm=%0d expected 10 0", n, bus_if.Position_pwm);
        end
    endtask

    task automatic test_saturation();
        int n;
        set_in(16'd2000, 16'd5000, 16'd100, 16'd0);
        wait_valid(n);
        checks++;
        if (bus_if.Position_pwm !== -16'sd32768 || bus_if.sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_low: pwm=%0d sat=%b expected -32768 1",
                     bus_if.Position_pwm, bus_if.sat);
        end
        set_in(16'd5000, 16'd2000, 16'd100, 16'd0);
        wait_valid(n);
        checks++;
        if (bus_if.Position_pwm !== 16'sd32767 || bus_if.sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_high: pwm=%0d sat=%b expected 32767 1",
                     bus_if.Position_pwm, bus_if.sat);
        end
    endtask

    task automatic test_enable_toggle();
        int n;
        int pulses;
        // err=-1000 after err_prev=3000: derr=-4000, sum -5000
        set_in(16'd2000, 16'd3000, 16'd1, 16'd1);
        wait_valid(n);
        checks++;
        if (bus_if.Position_pwm !== -16'sd5000 || bus_if.sat !== 1'b0) begin
            errors++;
            $display("FAIL en_pre: pwm=%0d sat=%b expected -5000 0",
                     bus_if.Position_pwm, bus_if.sat);
        end
        bus_if.enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.pwm_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL en_quiet: got %0d pulses expected 0", pulses);
        end
        bus_if.Sensor = 16'd2200;
        bus_if.enable = 1'b1;
        wait_valid(n);
        checks++;
        if (n != 14 || bus_if.Position_pwm !== -16'sd200) begin
            errors++;
            $display("FAIL en_resume: edges=%0d pwm=%0d expected 14 -200", n, bus_if.Position_pwm);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        // valid is in OUT; the next tick's MUL_D is 8 cycles later
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b expected 1", bus_if.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus_if.Position_pwm !== 16'sd0 || bus_if.busy !== 1'b0 ||
            bus_if.pwm_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: pwm=%0d busy=%b valid=%b expected 0 0 0",
                     bus_if.Position_pwm, bus_if.busy, bus_if.pwm_valid);
        end
        wait_valid(n);
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL mid_restart: got %0d edges expected 14", n);
        end
    endtask

    task automatic test_deadband();
        int n;
        logic signed [15:0] exp_pwm;
`ifdef PD_DEADBAND_EN
        exp_pwm = 16'sd0;
`else
        exp_pwm = -16'sd30;
`endif
        rst = 1'b1;
        set_in(16'd2000, 16'd2003, 16'd10, 16'd10);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_valid(n);
        checks++;
        if (n != 14 || bus_if.Position_pwm !== exp_pwm) begin
            errors++;
            $display("FAIL deadband: edges=%0d pwm=%0d expected 14 %0d", n, bus_if.Position_pwm,
                     exp_pwm);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic signed [15:0] exp_pwm;
`ifdef PD_DEADBAND_EN
        exp_pwm = 16'sd0;
`else
        exp_pwm = -16'sd30;
`endif
        wait_valid(n);
        checks++;
        if (n != 10 || bus_if.Position_pwm !== exp_pwm) begin
            errors++;
            $display("FAIL back_to_back: edges=%0d pwm=%0d expected 10 %0d", n,
                     bus_if.Position_pwm, exp_pwm);
        end
    endtask

    initial begin
        test_reset();
        test_basic_p();
        test_derivative();
        test_saturation();
        test_enable_toggle();
        test_reset_mid();
        test_deadband();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/position_pd_sequencer.md
Name: position_pd_sequencer

Overview:
Periodic control-loop sequencer for the position PD path. It generates the control-rate sample tick and latches sensor, target and gains once per tick. It then time-multiplexes one shared 17x17 signed multiplier across the proportional and derivative terms, and sums, saturates and publishes the PWM command with a one-cycle valid strobe. It sits between the raw sensor/gain registers and the motor PWM stage.

Parameters:
DIV, 1000, clock cycles per control tick; legal range 8..65535
OUT_MAX, 32767, upper saturation limit of position_pwm (signed)
OUT_MIN, -32768, lower saturation limit of position_pwm (signed); must be less than OUT_MAX
DEADBAND, 4, error magnitude treated as zero; used only when PD_DEADBAND_EN is defined

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  loop enable
Sensor  input  16  measured position, unsigned
positon_target  input  16  target position, unsigned
posi_kp  input  16  proportional gain, unsigned
posi_kd  input  16  derivative gain, unsigned
Position_pwm  output  16  PWM command, signed two's complement, registered
pwm_valid  output  1  one-cycle strobe when Position_pwm updates
busy  output  1  high while the FSM is not in IDLE
sat  output  1  registered with Position_pwm; high if the last result was clamped

Behaviour:
- Reset (rst=1 at a clk edge):
  - tick counter=0; FSM=IDLE; Position_pwm=0; pwm_valid=0; busy=0; sat=0
  - err_prev=0; first flag=1
  - reset overrides any in-flight sequence.
- Tick counter:
  - enable=1: counts 0..DIV-1 and wraps.
  - The internal tick is the cycle with counter==DIV-1.
  - enable=0: counter is held at 0, first flag is set to 1, and no new tick fires. An in-flight sequence still completes.
- FSM, one state per clock:
  - IDLE -> SAMPLE on tick.
  - SAMPLE: latch the four inputs; err = target - sensor (17-bit signed). If first=1 then derr=0 and first is cleared; else derr = err - err_prev (18-bit signed). err_prev <= err.
  - MUL_P: acc = err * kp (kp zero-extended to 17 bits).
  - MUL_D: acc = acc + sat18to17(derr) * kd. derr is clamped to the 17-bit signed range before multiplying. acc is 36-bit signed.
  - SAT: clamp acc to [OUT_MIN, OUT_MAX].
  - OUT: register Position_pwm and sat, pulse pwm_valid for exactly one cycle, then go to IDLE.
- Latency: pwm_valid is high 5 cycles after the tick cycle. Tick at cycle T gives SAMPLE at T+1 and pwm_valid at T+5.
- DIV >= 8 guarantees the FSM is in IDLE before the next tick.
- Only one multiplier instance is permitted. P and D products must share it.
- Input changes outside SAMPLE have no effect on the current sequence.
- Position_pwm holds its value between updates.

Optional Feature:
PD_DEADBAND_EN
- Defined: in SAMPLE, if |err| <= DEADBAND then err is replaced by 0 before computing derr and before storing err_prev.
- Not defined: no deadband logic is generated and DEADBAND is ignored.

Test Plan:
- Basic P with no derivative kick. DIV=10, kp=1, kd=1, target=2000, Sensor=5000, enable=1 from reset -> first pwm_valid gives Position_pwm=-3000, sat=0. Valid occurs 5 cycles after the counter reaches 9.
- Derivative term. Continue the previous case with Sensor=3000 before the second tick -> err=-1000, derr=2000, Position_pwm=1000. Then Sensor=2500 -> err=-500, derr=500, Position_pwm=0.
- Saturation. kp=100, kd=0, target=2000, Sensor=5000 -> Position_pwm=-32768, sat=1. With target=5000, Sensor=2000 -> Position_pwm=32767, sat=1.
- Enable toggle. Run with Sensor=3000, then drop enable for 50 cycles, then set Sensor=2200 and re-enable -> no pwm_valid while disabled. The next result uses derr=0, giving Position_pwm=-200 (kp=1, kd=1).
- Reset mid-sequence. Assert rst in the MUL_D cycle -> next cycle Position_pwm=0, busy=0, pwm_valid never pulses for that tick, and the counter restarts at 0.
- Deadband. kp=10, kd=10, target=2000, Sensor=2003, first tick -> with PD_DEADBAND_EN: Position_pwm=0. Without it: Position_pwm=-30.
